// File: rtl/garegga_pal_wr.sv
// Purpose: 68000-side writer/reader for the 2048x16 xBGR555 palette RAM (port B).
// Latency: write ACK 1 cycle after REQ rise; idle read ACK+data 3 cycles after REQ rise.
// Backpressure: write held (no ACK) while FIFO full; read held until FIFO drained and commit idle.
//
// Ports:
//   CLK96, RESET96       clock, asynchronous active-high reset
//   LVBL, LHBL           active-low blanking, gate RAM commits when BLANK_ONLY=1
//   CPU_REQ/RNW/ADDR/DIN/BE -> CPU_DOUT/CPU_ACK   CPU access handshake
//   RAM_ADDR/WE/WDATA/RDATA                         palette RAM port B
//   BUSY                 work queued, committing or a CPU access outstanding

// Small generic FIFO: registered pointers with one extra wrap bit, so the
// empty/full flags always reflect the count after the last push/pop.
module garegga_pal_fifo #(
    parameter int DW = 29,
    parameter int AW = 2
) (
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          push,
    input  logic [DW-1:0] wdat,
    input  logic          pop,
    output logic [DW-1:0] rdat,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK96) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdat;
    end

    assign rdat  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module garegga_pal_wr #(
    parameter int FIFO_AW    = 2,
    parameter bit BLANK_ONLY = 1'b0
) (
    input  logic        CLK96,
    input  logic        RESET96,
    input  logic        LVBL,
    input  logic        LHBL,
    input  logic        CPU_REQ,
    input  logic        CPU_RNW,
    input  logic [10:0] CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    input  logic [1:0]  CPU_BE,
    output logic [15:0] CPU_DOUT,
    output logic        CPU_ACK,
    output logic [10:0] RAM_ADDR,
    output logic        RAM_WE,
    output logic [15:0] RAM_WDATA,
    input  logic [15:0] RAM_RDATA,
    output logic        BUSY
);
    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
    } pal_wr_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FULLWR = 3'd1,
        RMW_RD = 3'd2,
        RMW_WT = 3'd3,
        RMW_WR = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        req_q;
    logic        req_rise;
    logic        pend_vld;
    logic        pend_rnw;
    logic [10:0] pend_addr;
    logic [15:0] pend_din;
    logic [1:0]  pend_be;

    logic        act_vld;
    logic        act_rnw;
    logic [10:0] act_addr;
    logic [15:0] act_din;
    logic [1:0]  act_be;
    logic        wr_go;
    logic        rd_go;

    pal_wr_t     push_dat;
    pal_wr_t     head;
    logic [$bits(pal_wr_t)-1:0] head_raw;
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_full;

    logic [1:0]  rd_st;
    logic [10:0] rd_addr;
    logic [15:0] merge_q;
    logic        commit_ok;

    // A held REQ only triggers once; the edge is serviced immediately if
    // possible, otherwise parked in the pend registers until it can be.
    assign req_rise = CPU_REQ && !req_q;
    assign act_vld  = pend_vld || req_rise;
    assign act_rnw  = pend_vld ? pend_rnw  : CPU_RNW;
    assign act_addr = pend_vld ? pend_addr : CPU_ADDR;
    assign act_din  = pend_vld ? pend_din  : CPU_DIN;
    assign act_be   = pend_vld ? pend_be   : CPU_BE;

    assign wr_go = act_vld && !act_rnw && !fifo_full;
    // Reads wait for every queued write to land so they never return stale colour.
    assign rd_go = act_vld && act_rnw && fifo_empty && (state_q == IDLE) && (rd_st == 2'd0);

    assign push_dat.addr = act_addr;
    assign push_dat.din  = act_din;
    assign push_dat.be   = (act_be == 2'b00) ? 2'b11 : act_be;

    assign head     = head_raw;
    assign fifo_pop = (state_q == FULLWR) || (state_q == RMW_WR);

    garegga_pal_fifo #(
        .DW ($bits(pal_wr_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .CLK96   (CLK96),
        .RESET96 (RESET96),
        .push    (wr_go),
        .wdat    (push_dat),
        .pop     (fifo_pop),
        .rdat    (head_raw),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // CPU request capture and read sequencing
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            req_q     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_rnw  <= 1'b0;
            pend_addr <= '0;
            pend_din  <= '0;
            pend_be   <= '0;
            rd_st     <= 2'd0;
            rd_addr   <= '0;
            CPU_DOUT  <= '0;
            CPU_ACK   <= 1'b0;
        end else begin
            req_q <= CPU_REQ;
            if (wr_go || rd_go) begin
                pend_vld <= 1'b0;
            end else if (req_rise) begin
                pend_vld  <= 1'b1;
                pend_rnw  <= CPU_RNW;
                pend_addr <= CPU_ADDR;
                pend_din  <= CPU_DIN;
                pend_be   <= CPU_BE;
            end
            // rd_st 1: address presented; 2: RAM data valid, capture it.
            case (rd_st)
                2'd0: begin
                    if (rd_go) begin
                        rd_addr <= act_addr;
                        rd_st   <= 2'd1;
                    end
                end
                2'd1: rd_st <= 2'd2;
                2'd2: begin
                    CPU_DOUT <= RAM_RDATA;
                    rd_st    <= 2'd0;
                end
                default: rd_st <= 2'd0;
            endcase
            CPU_ACK <= wr_go || (rd_st == 2'd2);
        end
    end

    // Commit FSM: state register
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RMW_WT) begin
                merge_q <= {head.be[1] ? head.din[15:8] : RAM_RDATA[15:8],
                            head.be[0] ? head.din[7:0]  : RAM_RDATA[7:0]};
            end
        end
    end

    // Blanking gate is sampled only when leaving IDLE; an RMW in flight finishes.
    assign commit_ok = !BLANK_ONLY || !LVBL || !LHBL;

    // Commit FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && commit_ok && (rd_st == 2'd0)) begin
                    state_d = (head.be == 2'b11) ? FULLWR : RMW_RD;
                end
            end
            FULLWR:  state_d = IDLE;
            RMW_RD:  state_d = RMW_WT;
            RMW_WT:  state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Commit FSM: outputs. Read sequencing owns RAM_ADDR whenever the FSM is idle.
    always_comb begin
        RAM_WE    = 1'b0;
        RAM_WDATA = '0;
        RAM_ADDR  = rd_addr;
        case (state_q)
            FULLWR: begin
                RAM_ADDR  = head.addr;
                RAM_WDATA = head.din;
                RAM_WE    = 1'b1;
            end
            RMW_RD, RMW_WT: begin
                RAM_ADDR = head.addr;
            end
            RMW_WR: begin
                RAM_ADDR  = head.addr;
                RAM_WDATA = merge_q;
                RAM_WE    = 1'b1;
            end
            default: begin
                RAM_ADDR = rd_addr;
            end
        endcase
    end

    assign BUSY = !fifo_empty || (state_q != IDLE) || pend_vld || (rd_st != 2'd0);
endmodule

// File: tb/tb_garegga_pal_wr.sv
// Purpose: self-checking bench for garegga_pal_wr with a behavioural port-B RAM.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_garegga_pal_wr;
    logic        CLK96 = 1'b0;
    logic        RESET96 = 1'b1;
    logic        LVBL = 1'b1;
    logic        LHBL = 1'b0;
    logic        CPU_REQ = 1'b0;
    logic        CPU_RNW = 1'b0;
    logic [10:0] CPU_ADDR = '0;
    logic [15:0] CPU_DIN = '0;
    logic [1:0]  CPU_BE = '0;
    logic [15:0] CPU_DOUT;
    logic        CPU_ACK;
    logic [10:0] RAM_ADDR;
    logic        RAM_WE;
    logic [15:0] RAM_WDATA;
    logic [15:0] RAM_RDATA = '0;
    logic        BUSY;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_wr[$];
    wr_t mon_e;

    typedef struct {
        logic        rnw;
        logic [10:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
        logic [15:0] exp;
        int          lat;
        bit          idle;
    } vec_t;
    vec_t vecs[11];

    always #5 CLK96 = ~CLK96;

    garegga_pal_wr #(
        .FIFO_AW    (2),
        .BLANK_ONLY (1'b1)
    ) dut (
        .CLK96     (CLK96),
        .RESET96   (RESET96),
        .LVBL      (LVBL),
        .LHBL      (LHBL),
        .CPU_REQ   (CPU_REQ),
        .CPU_RNW   (CPU_RNW),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_DIN   (CPU_DIN),
        .CPU_BE    (CPU_BE),
        .CPU_DOUT  (CPU_DOUT),
        .CPU_ACK   (CPU_ACK),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_WE    (RAM_WE),
        .RAM_WDATA (RAM_WDATA),
        .RAM_RDATA (RAM_RDATA),
        .BUSY      (BUSY)
    );

    // Port-B RAM model: synchronous, 1-cycle read latency, preloaded on first edge.
    bit ram_ready = 1'b0;
    logic [15:0] ram [0:2047];
    always @(posedge CLK96) begin
        if (!ram_ready) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 16'h0000;
            ram[11'h020] <= 16'hABCD;
            ram[11'h040] <= 16'h1111;
            ram_ready <= 1'b1;
        end else if (RAM_WE) begin
            ram[RAM_ADDR] <= RAM_WDATA;
        end
        RAM_RDATA <= ram[RAM_ADDR];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the next expected commit, in order.
    always @(negedge CLK96) begin
        if (RAM_WE) begin
            we_cnt++;
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ram_write: addr %h data %h, no write expected", RAM_ADDR, RAM_WDATA);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("ram_wr_addr", {21'd0, RAM_ADDR}, {21'd0, mon_e.addr});
                chk("ram_wr_data", {16'd0, RAM_WDATA}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic cpu_access(input logic rnw, input logic [10:0] addr, input logic [15:0] din,
                              input logic [1:0] be, input logic [15:0] exp, input int exp_lat,
                              input bit push_exp, input string name);
        int lat;
        if (!rnw && push_exp) exp_wr.push_back({addr, exp});
        @(negedge CLK96);
        CPU_REQ  = 1'b1;
        CPU_RNW  = rnw;
        CPU_ADDR = addr;
        CPU_DIN  = din;
        CPU_BE   = be;
        lat = 0;
        do begin
            @(negedge CLK96);
            lat++;
        end while (!CPU_ACK && lat < 200);
        CPU_REQ = 1'b0;
        if (!CPU_ACK) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: no ACK after %0d cycles, ACK required", name, lat);
        end else begin
            if (exp_lat > 0) chk({name, "_lat"}, lat, exp_lat);
            if (rnw) chk({name, "_dout"}, {16'd0, CPU_DOUT}, {16'd0, exp});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (BUSY && n < 200) begin
            @(negedge CLK96);
            n++;
        end
        if (BUSY) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: BUSY=1 after %0d cycles, 0 required", name, n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, completion required");
        $fatal(1, "timeout");
    end

    initial begin
        int  we0;
        int  n;
        int  acks;
        bit  found;
        bit  acked;

        vecs[0]  = '{1'b0, 11'h020, 16'h12FF, 2'b10, 16'h12CD, 1, 1'b1};
        vecs[1]  = '{1'b0, 11'h020, 16'h0034, 2'b01, 16'h1234, 1, 1'b0};
        vecs[2]  = '{1'b1, 11'h020, 16'h0000, 2'b11, 16'h1234, 0, 1'b0};
        vecs[3]  = '{1'b0, 11'h7FF, 16'h7FFF, 2'b11, 16'h7FFF, 1, 1'b1};
        vecs[4]  = '{1'b1, 11'h7FF, 16'h0000, 2'b11, 16'h7FFF, 0, 1'b0};
        vecs[5]  = '{1'b0, 11'h030, 16'h5555, 2'b00, 16'h5555, 1, 1'b1};
        vecs[6]  = '{1'b1, 11'h010, 16'h0000, 2'b11, 16'h0123, 3, 1'b1};
        vecs[7]  = '{1'b1, 11'h030, 16'h0000, 2'b11, 16'h5555, 3, 1'b1};
        vecs[8]  = '{1'b0, 11'h000, 16'hFFFF, 2'b01, 16'h00FF, 1, 1'b1};
        vecs[9]  = '{1'b1, 11'h000, 16'h0000, 2'b11, 16'h00FF, 3, 1'b1};
        vecs[10] = '{1'b1, 11'h7FF, 16'h0000, 2'b11, 16'h7FFF, 3, 1'b1};

        // Reset state
        repeat (3) @(negedge CLK96);
        chk("rst_cpu_dout", {16'd0, CPU_DOUT}, 32'd0);
        chk("rst_cpu_ack", {31'd0, CPU_ACK}, 32'd0);
        chk("rst_ram_addr", {21'd0, RAM_ADDR}, 32'd0);
        chk("rst_ram_we", {31'd0, RAM_WE}, 32'd0);
        chk("rst_ram_wdata", {16'd0, RAM_WDATA}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        RESET96 = 1'b0;
        @(negedge CLK96);

        // Full-word write, commit follows within 3 cycles of ACK
        cpu_access(1'b0, 11'h010, 16'h0123, 2'b11, 16'h0123, 1, 1'b1, "t1_write");
        chk("t1_busy_after_ack", {31'd0, BUSY}, 32'd1);
        found = 1'b0;
        for (int k = 0; k < 3 && !found; k++) begin
            @(negedge CLK96);
            if (RAM_WE) found = 1'b1;
        end
        chk("t1_commit_within_3", {31'd0, found}, 32'd1);
        wait_idle("t1");

        // Table: RMW merges, coherent reads, BE=00, idle read latency
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].idle) wait_idle($sformatf("vec%0d", i));
            cpu_access(vecs[i].rnw, vecs[i].addr, vecs[i].din, vecs[i].be, vecs[i].exp,
                       vecs[i].lat, 1'b1, $sformatf("vec%0d", i));
        end
        wait_idle("table");

        // FIFO full while commits stalled outside blanking
        LHBL = 1'b1;
        we0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            cpu_access(1'b0, 11'h100 + 11'(i), 16'hC000 + 16'(i), 2'b11, 16'hC000 + 16'(i), 1,
                       1'b1, $sformatf("t3_wr%0d", i));
        end
        exp_wr.push_back({11'h104, 16'hC004});
        @(negedge CLK96);
        CPU_REQ  = 1'b1;
        CPU_RNW  = 1'b0;
        CPU_ADDR = 11'h104;
        CPU_DIN  = 16'hC004;
        CPU_BE   = 2'b11;
        acked = 1'b0;
        repeat (10) begin
            @(negedge CLK96);
            if (CPU_ACK) acked = 1'b1;
        end
        chk("t3_full_no_ack", {31'd0, acked}, 32'd0);
        chk("t3_no_commit_stalled", we_cnt - we0, 32'd0);
        LHBL = 1'b0;
        n = 0;
        do begin
            @(negedge CLK96);
            n++;
        end while (!CPU_ACK && n < 50);
        CPU_REQ = 1'b0;
        chk("t3_fifth_ack", {31'd0, CPU_ACK}, 32'd1);
        chk("t3_fifth_ack_lat", n, 32'd3);
        wait_idle("t3");
        chk("t3_all_landed", we_cnt - we0, 32'd5);

        // Reset during RMW_WT with three entries queued
        LHBL = 1'b1;
        cpu_access(1'b0, 11'h040, 16'hAA00, 2'b10, 16'h0000, 1, 1'b0, "t5_wr0");
        cpu_access(1'b0, 11'h041, 16'h3333, 2'b11, 16'h0000, 1, 1'b0, "t5_wr1");
        cpu_access(1'b0, 11'h042, 16'h4444, 2'b11, 16'h0000, 1, 1'b0, "t5_wr2");
        we0 = we_cnt;
        LHBL = 1'b0;
        @(negedge CLK96);
        @(negedge CLK96);
        RESET96 = 1'b1;
        #1;
        chk("t5_we_in_reset", {31'd0, RAM_WE}, 32'd0);
        chk("t5_busy_in_reset", {31'd0, BUSY}, 32'd0);
        @(negedge CLK96);
        chk("t5_we_reset_held", {31'd0, RAM_WE}, 32'd0);
        RESET96 = 1'b0;
        repeat (6) @(negedge CLK96);
        chk("t5_no_write_after_abort", we_cnt - we0, 32'd0);
        chk("t5_busy_after", {31'd0, BUSY}, 32'd0);
        chk("t5_ram_unchanged", {16'd0, ram[11'h040]}, 32'h0000_1111);
        cpu_access(1'b0, 11'h050, 16'h2222, 2'b11, 16'h2222, 1, 1'b1, "t5_post_write");
        wait_idle("t5");
        chk("t5_post_ram", {16'd0, ram[11'h050]}, 32'h0000_2222);

        // REQ held for 20 cycles: one ACK, one RAM write
        we0 = we_cnt;
        exp_wr.push_back({11'h060, 16'h4321});
        @(negedge CLK96);
        CPU_REQ  = 1'b1;
        CPU_RNW  = 1'b0;
        CPU_ADDR = 11'h060;
        CPU_DIN  = 16'h4321;
        CPU_BE   = 2'b11;
        acks = 0;
        repeat (20) begin
            @(negedge CLK96);
            if (CPU_ACK) acks++;
        end
        CPU_REQ = 1'b0;
        wait_idle("t6");
        chk("t6_one_ack", acks, 32'd1);
        chk("t6_one_write", we_cnt - we0, 32'd1);

        repeat (5) @(negedge CLK96);
        chk("scoreboard_drained", exp_wr.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
